instr_prefetch_queue: RTL and testbench
=======================================

# instr_prefetch_queue

Parametrised instruction prefetch queue between the synchronous-read instruction ROM and the Hack CPU. It replaces the fixed stall/jmp handshake with a DEPTH-entry decoupling FIFO: it issues ROM fetches ahead of the CPU, holds returned words with their PCs, and presents them to the CPU with a valid/ready handshake. A taken jump flushes the queue, drops the in-flight ROM reply and restarts fetch at the jump target.

## Interface
- IW, 16: instruction width.
- AW, 15: instruction address width; the PC wraps modulo 2^AW.
- DEPTH, 4: queue entries, a power of two ≥ 2.
- RESET_PC, 0: first fetch address after reset.

- clk  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rom_en  out  1  ROM read request this cycle.
- rom_addr  out  AW  ROM read address.
- rom_data  in  IW  ROM read data, valid the cycle after rom_en.
- instr  out  IW  instruction at the queue head.
- instr_pc  out  AW  PC of instr.
- instr_valid  out  1  head entry is valid.
- instr_ready  in  1  CPU consumes the head this cycle; low means the CPU is stalled.
- jmp  in  1  taken jump (the CPU's loadPC).
- jmp_target  in  AW  jump destination.

## Operation
- State: fetch_pc (AW bits), count (0..DEPTH), inflight flag, FSM state, and DEPTH entries of {IW data, AW pc}.
- FSM states:
  - BOOT: first cycle after reset release; no fetch is issued. Always goes to RUN.
  - RUN: normal fetching. Goes to REDIRECT when jmp=1.
  - REDIRECT: one cycle. Goes to RUN, or stays in REDIRECT if jmp=1 again.
- Issue rule in RUN and REDIRECT: rom_en=1 when count + inflight < DEPTH. No credit is taken for a pop in the same cycle.
  - On issue, rom_addr = fetch_pc, then fetch_pc ← fetch_pc+1 (wrapping at 2^AW), and inflight ← 1.
- Return: when inflight was set in the previous cycle, push {rom_data, issued pc} at the tail.
  - In REDIRECT, the returning word is discarded and not pushed.
- Pop: when instr_valid && instr_ready, the head advances.
  - A push and a pop in the same cycle leave count unchanged.
- jmp=1 (any state except BOOT):
  - queue is cleared (count ← 0) and any same-cycle pop is ignored;
  - fetch_pc ← jmp_target, state ← REDIRECT;
  - rom_en is forced low this cycle, so inflight ← 0.
- REDIRECT issues at jmp_target immediately, because count=0.
- jmp during BOOT is ignored. The CPU is in reset then, so this case cannot occur in use.
- Outputs are driven from the registered head, so instr, instr_pc and instr_valid have no combinational path from instr_ready, jmp or rom_data.

## Timing
- Reset values:
  - rom_en=0, rom_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
  - count=0, inflight=0, fetch_pc=RESET_PC, state=BOOT.
- Reset release: BOOT lasts cycle 0. The first rom_en is in cycle 1 with addr RESET_PC.
- Fetch-to-valid latency is 2 cycles: issue in cycle N, push in cycle N+1, instr_valid from cycle N+2.
- With instr_ready held at 1, throughput is 1 instruction/cycle.
- Jump sampled in cycle J:
  - instr_valid=0 from J+1;
  - target issued in J+1;
  - target valid in J+3, so the taken-jump bubble is 2 cycles.
- Full: at count=DEPTH, or count=DEPTH-1 with inflight=1, rom_en stays 0 until a pop occurs.
- A mid-operation reset assertion clears all state asynchronously. No partial instruction is ever presented.

## Configuration
- PREFETCH_STATS_EN defined adds two saturating 16-bit output counters:
  - flush_cnt: +1 per accepted jmp;
  - stall_cnt: +1 per cycle with instr_valid && !instr_ready.
  - Both reset to 0.
- Undefined: those ports and registers do not exist, and behaviour is otherwise identical.

## Structure
- Shared package prefetch_pkg holds:
  - the FSM state typedef {BOOT, RUN, REDIRECT};
  - the queue entry struct {data, pc};
  - the stats counter width constant (16).
- One sub-module, pq_fifo: a DEPTH×(IW+AW) circular buffer with head/tail pointers, count, push, pop and clear. Wrap-around comes from pointer width log2(DEPTH).
- The top level holds the FSM, fetch_pc, the inflight flag and the issue logic.

## Test plan
- Reset release with ROM[i]=i+100 and ready=1: rom_en first in cycle 1 (addr 0); instr_valid in cycle 3 with instr=100, pc=0; afterwards one increment per cycle.
- ready=0 held, DEPTH=4: exactly 4 fetches issued (addrs 0–3), then rom_en=0. Raising ready yields 100, 101, 102, 103, 104 in consecutive cycles.
- jmp with target 20 while the queue holds 3 entries and a reply is in flight: instr_valid=0 for 2 cycles. Next valid has pc=20, instr=120, and no stale word appears.
- jmp on consecutive cycles, targets 5 then 9: only pc=9 (instr=109) is presented, 2 cycles after the second jmp.
- fetch_pc=2^AW−1 with ROM[32767]=7: the sequence is pc=32767 then pc=0 with no gap. Asserting reset mid-stream drops instr_valid at once and restarts at RESET_PC.
- PREFETCH_STATS_EN builds: 3 jumps and 5 stalled-valid cycles give flush_cnt=3 and stall_cnt=5.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared types for the Hack instruction prefetch queue.
// PREFETCH_STATS_EN enables the flush/stall counter ports.
package prefetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIRECT
  } pq_state_e;

  localparam int HACK_IW = 16;
  localparam int HACK_AW = 15;

  typedef struct packed {
    logic [HACK_IW-1:0] data;
    logic [HACK_AW-1:0] pc;
  } pq_entry_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/pq_fifo.sv
// Circular buffer of DEPTH entries; pointers wrap by their own width.
// Clear has priority over push and pop.
module pq_fifo
  import prefetch_pkg::*;
#(
  parameter int W     = HACK_IW + HACK_AW,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL) || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PW'(1);
      if (do_pop)  head_d = head_q + PW'(1);
      if (do_push && !do_pop)
        count_d = count_q + CW'(1);
      else if (!do_push && do_pop)
        count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entries are cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (!clear_i && do_push) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Prefetch queue between the sync-read instruction ROM and the Hack CPU.
// Define PREFETCH_STATS_EN to add flush_cnt / stall_cnt outputs.
module instr_prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int             IW       = 16,
  parameter int             AW       = 15,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [IW-1:0] rom_data,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_target
`ifdef PREFETCH_STATS_EN
  ,
  output logic [STATS_W-1:0] flush_cnt,
  output logic [STATS_W-1:0] stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] LIMIT = DEPTH[CW:0];

  typedef struct packed {
    logic [IW-1:0] data;
    logic [AW-1:0] pc;
  } entry_t;

  pq_state_e     state_q;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] issue_pc_q;
  logic          inflight_q;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          take_jmp, push, pop;
  entry_t        head, tail;

  assign take_jmp  = jmp && (state_q != BOOT);
  // A same-cycle pop earns no credit: occupancy uses registered count.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign rom_en    = (state_q != BOOT) && !jmp && (occupancy < LIMIT);
  assign rom_addr  = fetch_pc_q;

  assign push = inflight_q && (state_q != REDIRECT);
  assign pop  = instr_valid && instr_ready;
  assign tail = '{data: rom_data, pc: issue_pc_q};

  pq_fifo #(
    .W     (IW + AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (take_jmp),
    .push_i  (push),
    .wdata_i (tail),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign instr       = head.data;
  assign instr_pc    = head.pc;
  assign instr_valid = (count != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (take_jmp)
      fetch_pc_d = jmp_target;
    else if (rom_en)
      fetch_pc_d = fetch_pc_q + AW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= rom_en;
      if (rom_en) issue_pc_q <= fetch_pc_q;
      unique case (state_q)
        BOOT:     state_q <= RUN;
        RUN:      state_q <= jmp ? REDIRECT : RUN;
        REDIRECT: state_q <= jmp ? REDIRECT : RUN;
        default:  state_q <= BOOT;
      endcase
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [STATS_W-1:0] flush_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (take_jmp && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + STATS_W'(1);
      if (instr_valid && !instr_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + STATS_W'(1);
    end
  end

  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a sync-read ROM model.
// ROM[a] = a+100, except ROM[32767] = 7.
module tb_instr_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        rom_en;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [14:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jmp;
  logic [14:0] jmp_target;
`ifdef PREFETCH_STATS_EN
  logic [15:0] flush_cnt;
  logic [15:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  instr_prefetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jmp         (jmp),
    .jmp_target  (jmp_target)
`ifdef PREFETCH_STATS_EN
    ,
    .flush_cnt   (flush_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [14:0] a);
    if (a == 15'h7fff) return 16'd7;
    return 16'(a) + 16'd100;
  endfunction

  initial rom_data = '0;
  always @(posedge clk)
    if (rom_en) rom_data <= rom_word(rom_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Leaves the bench in cycle 0 (BOOT) after release.
  task automatic restart(input logic rdy);
    instr_ready = rdy;
    jmp = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    jmp = 1'b0;
    jmp_target = '0;
    instr_ready = 1'b1;
    step();

    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_valid", 32'(instr_valid), 0);
`ifdef PREFETCH_STATS_EN
    chk("rst_flush", 32'(flush_cnt), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
`endif

    // boot latency and streaming
    reset = 1'b1;
    #1;
    chk("boot_rom_en", 32'(rom_en), 0);
    step();
    chk("c1_rom_en", 32'(rom_en), 1);
    chk("c1_addr", 32'(rom_addr), 0);
    chk("c1_valid", 32'(instr_valid), 0);
    step();
    chk("c2_addr", 32'(rom_addr), 1);
    chk("c2_valid", 32'(instr_valid), 0);
    step();
    chk("c3_valid", 32'(instr_valid), 1);
    chk("c3_instr", 32'(instr), 100);
    chk("c3_pc", 32'(instr_pc), 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("stream_instr", 32'(instr), 32'(100 + k));
      chk("stream_pc", 32'(instr_pc), 32'(k));
    end

    // fill with CPU stalled, then drain
    restart(1'b0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("fill_rom_en", 32'(rom_en), 1);
      chk("fill_addr", 32'(rom_addr), 32'(c - 1));
    end
    step();
    chk("full_rom_en_c5", 32'(rom_en), 0);
    step();
    chk("full_rom_en_c6", 32'(rom_en), 0);
    chk("full_instr", 32'(instr), 100);
    step();
    instr_ready = 1'b1;
    #1;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      chk("drain_valid", 32'(instr_valid), 1);
      chk("drain_instr", 32'(instr), 32'(100 + k));
    end

    // jump with 3 queued entries and a reply in flight
    restart(1'b0);
    repeat (5) step();
    jmp = 1'b1;
    jmp_target = 15'd20;
    #1;
    chk("jmp_rom_en", 32'(rom_en), 0);
    step();
    jmp = 1'b0;
    #1;
    chk("jmp1_valid", 32'(instr_valid), 0);
    chk("jmp1_rom_en", 32'(rom_en), 1);
    chk("jmp1_addr", 32'(rom_addr), 20);
    step();
    chk("jmp2_valid", 32'(instr_valid), 0);
    step();
    chk("jmp3_valid", 32'(instr_valid), 1);
    chk("jmp3_instr", 32'(instr), 120);
    chk("jmp3_pc", 32'(instr_pc), 20);
    instr_ready = 1'b1;
    #1;
    step();
    chk("jmp4_instr", 32'(instr), 121);
    chk("jmp4_pc", 32'(instr_pc), 21);

    // back-to-back jumps: only the second target survives
    restart(1'b1);
    repeat (4) step();
    jmp = 1'b1;
    jmp_target = 15'd5;
    #1;
    step();
    jmp_target = 15'd9;
    #1;
    chk("bb1_valid", 32'(instr_valid), 0);
    chk("bb1_rom_en", 32'(rom_en), 0);
    step();
    jmp = 1'b0;
    #1;
    chk("bb2_valid", 32'(instr_valid), 0);
    chk("bb2_addr", 32'(rom_addr), 9);
    step();
    chk("bb3_valid", 32'(instr_valid), 0);
    step();
    chk("bb4_valid", 32'(instr_valid), 1);
    chk("bb4_instr", 32'(instr), 109);
    chk("bb4_pc", 32'(instr_pc), 9);
    step();
    chk("bb5_instr", 32'(instr), 110);

    // PC wrap at the top of the address space
    jmp = 1'b1;
    jmp_target = 15'h7fff;
    #1;
    step();
    jmp = 1'b0;
    step();
    step();
    chk("wrap_pc_hi", 32'(instr_pc), 32767);
    chk("wrap_instr_hi", 32'(instr), 7);
    step();
    chk("wrap_pc_0", 32'(instr_pc), 0);
    chk("wrap_instr_0", 32'(instr), 100);
    step();
    chk("wrap_pc_1", 32'(instr_pc), 1);

    // asynchronous reset mid-stream
    reset = 1'b0;
    #1;
    chk("areset_valid", 32'(instr_valid), 0);
    chk("areset_rom_en", 32'(rom_en), 0);
    chk("areset_addr", 32'(rom_addr), 0);
    chk("areset_instr", 32'(instr), 0);
    step();
    reset = 1'b1;
    #1;
    chk("rerun_boot", 32'(rom_en), 0);
    step();
    chk("rerun_addr", 32'(rom_addr), 0);
    step();
    step();
    chk("rerun_valid", 32'(instr_valid), 1);
    chk("rerun_instr", 32'(instr), 100);
    chk("rerun_pc", 32'(instr_pc), 0);

`ifdef PREFETCH_STATS_EN
    // 5 stalled-valid cycles (3..7), then 3 jumps
    restart(1'b0);
    repeat (8) step();
    instr_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      jmp = 1'b1;
      jmp_target = 15'(40 + j);
      step();
      jmp = 1'b0;
      repeat (3) step();
    end
    chk("flush_cnt", 32'(flush_cnt), 3);
    chk("stall_cnt", 32'(stall_cnt), 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
